// File: rtl/neuron_seq.sv
// neuron_seq: sequential neuron, MAC over N_IN pairs then piecewise-linear sigmoid.
// Optional sigmoid-derivative stage enabled by NEURON_SIGMA_PRIME_EN.
module neuron_seq #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24,
   parameter int N_IN  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] bias,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] prev_activ,
   input  logic [WIDTH-1:0] weight,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] activ,
   output logic [WIDTH-1:0] sigma_prime,
   output logic             busy
);

   localparam int CW = $clog2(N_IN + 1);
   localparam int AW = 2 * WIDTH + CW;
   localparam int PW = 2 * WIDTH;

   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1) << FRAC;
   localparam logic [WIDTH-1:0] HALF  = ONE >> 1;
   localparam logic [WIDTH-1:0] FIVE  = WIDTH'(5) << FRAC;
   localparam logic [WIDTH-1:0] K2375 = (WIDTH'(19) << FRAC) >> 3;
   localparam logic [WIDTH-1:0] C0843 = (WIDTH'(27) << FRAC) >> 5;
   localparam logic [WIDTH-1:0] C0625 = (WIDTH'(5) << FRAC) >> 3;

   localparam logic signed [AW-1:0] SMAX =
      {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SMIN =
      {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

`ifdef NEURON_SIGMA_PRIME_EN
   typedef enum logic [2:0] {
      IDLE, ACCUM, ACT, SPRIME, DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, ACCUM, ACT, DONE
   } state_t;
`endif

   state_t state_q, state_d;

   logic signed [AW-1:0] acc_q;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     activ_q;

   logic                 accept;
   logic                 last;
   logic signed [PW-1:0] pa_ext, w_ext, prod;
   logic signed [AW-1:0] prod_ext, bias_ext, bias_sh;
   logic signed [AW-1:0] sh;
   logic [WIDTH-1:0]     x, ax, y, sig;

   // FSM: state register and next-state/output decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && last) state_d = ACT;
         end
`ifdef NEURON_SIGMA_PRIME_EN
         ACT:    state_d = SPRIME;
         SPRIME: state_d = DONE;
`else
         ACT:    state_d = DONE;
`endif
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid && (state_q == ACCUM);
   assign last   = (cnt_q == CW'(N_IN - 1));

   // full-precision MAC operands
   assign pa_ext   = {{WIDTH{prev_activ[WIDTH-1]}}, prev_activ};
   assign w_ext    = {{WIDTH{weight[WIDTH-1]}}, weight};
   assign prod     = pa_ext * w_ext;
   assign prod_ext = {{CW{prod[PW-1]}}, prod};
   assign bias_ext = {{(AW-WIDTH){bias[WIDTH-1]}}, bias};
   assign bias_sh  = bias_ext <<< FRAC;

   // back to Q format, saturated to the word range
   assign sh = acc_q >>> FRAC;

   always_comb begin
      x = sh[WIDTH-1:0];
      if (sh > SMAX)      x = SMAX[WIDTH-1:0];
      else if (sh < SMIN) x = SMIN[WIDTH-1:0];
   end

   // |x| fits unsigned even for the most negative word
   assign ax = x[WIDTH-1] ? -x : x;

   always_comb begin
      y = (ax >> 2) + HALF;
      if (ax >= FIVE)       y = ONE;
      else if (ax >= K2375) y = (ax >> 5) + C0843;
      else if (ax >= ONE)   y = (ax >> 3) + C0625;
   end

   assign sig = x[WIDTH-1] ? ONE - y : y;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         activ_q <= '0;
      end else begin
         if (state_q == IDLE && start) begin
            acc_q <= bias_sh;
            cnt_q <= '0;
         end else if (accept) begin
            acc_q <= acc_q + prod_ext;
            cnt_q <= cnt_q + CW'(1);
         end
         if (state_q == ACT) activ_q <= sig;
      end
   end

   assign activ = activ_q;

`ifdef NEURON_SIGMA_PRIME_EN
   logic [WIDTH-1:0] sp_q;
   logic [PW-1:0]    sp_full;
   logic             unused_sp;

   assign sp_full = {{WIDTH{1'b0}}, activ_q} *
                    {{WIDTH{1'b0}}, ONE - activ_q};
   assign unused_sp = ^{sp_full[PW-1:FRAC+WIDTH], sp_full[FRAC-1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  sp_q <= '0;
      else if (state_q == SPRIME) sp_q <= sp_full[FRAC +: WIDTH];
   end

   assign sigma_prime = sp_q;
`else
   assign sigma_prime = '0;
`endif

endmodule

// File: tb/tb_neuron_seq.sv
// Directed bench for neuron_seq: known sigmoid points, saturation,
// stalls, backpressure, mid-run reset and a single-input instance.
module tb_neuron_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start1;
   logic [31:0] bias;
   logic        in_valid;
   logic        in_ready, in_ready1;
   logic [31:0] prev_activ, weight;
   logic        out_valid, out_valid1;
   logic        out_ready, out_ready1;
   logic [31:0] activ, activ1;
   logic [31:0] sigma_prime, sigma_prime1;
   logic        busy, busy1;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef NEURON_SIGMA_PRIME_EN
   localparam int EXP_LAT = 3;
`else
   localparam int EXP_LAT = 2;
`endif

   always #5 clk = ~clk;

   neuron_seq #(.WIDTH(32), .FRAC(24), .N_IN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready),
      .prev_activ(prev_activ), .weight(weight),
      .out_valid(out_valid), .out_ready(out_ready),
      .activ(activ), .sigma_prime(sigma_prime), .busy(busy)
   );

   neuron_seq #(.WIDTH(32), .FRAC(24), .N_IN(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready1),
      .prev_activ(prev_activ), .weight(weight),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .activ(activ1), .sigma_prime(sigma_prime1), .busy(busy1)
   );

   function automatic logic [31:0] spx(input logic [31:0] v);
`ifdef NEURON_SIGMA_PRIME_EN
      return v;
`else
      return 32'h0 & v;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_eval(input string tag, input logic [31:0] b,
                           input logic [31:0] pa, input logic [31:0] w,
                           input bit gaps, input int hold,
                           input bit start_in_done,
                           input logic [31:0] ea, input logic [31:0] es);
      int lat;
      bias  = b;
      start = 1'b1;
      step;
      start = 1'b0;
      bias  = 32'h0;
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      for (int i = 0; i < 32; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            start    = 1'b1;
            step;
            start    = 1'b0;
         end
         prev_activ = pa;
         weight     = w;
         in_valid   = 1'b1;
         if (i == 0) chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
         step;
      end
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         step;
         lat++;
      end
      chk({tag, "_lat"}, lat, EXP_LAT);
      chk({tag, "_activ"}, activ, ea);
      chk({tag, "_sp"}, sigma_prime, es);
      for (int i = 0; i < hold; i++) begin
         step;
         chk({tag, "_hold_v"}, {31'b0, out_valid}, 32'd1);
         chk({tag, "_hold_a"}, activ, ea);
         chk({tag, "_hold_s"}, sigma_prime, es);
      end
      out_ready = 1'b1;
      if (start_in_done) start = 1'b1;
      step;
      out_ready = 1'b0;
      start     = 1'b0;
      chk({tag, "_ov0"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
      chk({tag, "_keep"}, activ, ea);
   endtask

   initial begin
      int lat;
      rst        = 1'b1;
      start      = 1'b0;
      start1     = 1'b0;
      bias       = 32'h0;
      in_valid   = 1'b0;
      prev_activ = 32'h0;
      weight     = 32'h0;
      out_ready  = 1'b0;
      out_ready1 = 1'b0;
      step;
      step;
      chk("rst_activ", activ, 32'h0);
      chk("rst_sp", sigma_prime, 32'h0);
      chk("rst_ov", {31'b0, out_valid}, 32'd0);
      chk("rst_ir", {31'b0, in_ready}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      step;

      run_eval("zero", 32'h0, 32'h0, 32'h0, 1'b0, 2, 1'b0,
               32'h0080_0000, spx(32'h0040_0000));
      run_eval("bias_m1", 32'hFF00_0000, 32'h0, 32'h0, 1'b0, 0, 1'b0,
               32'h0040_0000, spx(32'h0030_0000));
      run_eval("bias_m2", 32'hFE00_0000, 32'h0, 32'h0, 1'b0, 0, 1'b0,
               32'h0020_0000, spx(32'h001C_0000));
      run_eval("sum32", 32'h0, 32'h0100_0000, 32'h0100_0000, 1'b0, 0,
               1'b0, 32'h0100_0000, 32'h0);
      run_eval("sat_pos", 32'h0, 32'h6400_0000, 32'h6400_0000, 1'b0, 0,
               1'b0, 32'h0100_0000, 32'h0);
      run_eval("sat_neg", 32'h0, 32'h6400_0000, 32'h9C00_0000, 1'b0, 0,
               1'b0, 32'h0, 32'h0);
      run_eval("sat_pos2", 32'h0, 32'h6400_0000, 32'h6400_0000, 1'b0, 0,
               1'b0, 32'h0100_0000, 32'h0);

      // reset in the middle of accumulation
      start = 1'b1;
      step;
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         prev_activ = 32'h0100_0000;
         weight     = 32'h0100_0000;
         in_valid   = 1'b1;
         step;
      end
      in_valid = 1'b0;
      chk("pre_rst_busy", {31'b0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_activ", activ, 32'h0);
      chk("mid_rst_sp", sigma_prime, 32'h0);
      chk("mid_rst_ov", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_ir", {31'b0, in_ready}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      step;
      rst = 1'b0;
      step;
      run_eval("post_rst", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0,
               32'h0080_0000, spx(32'h0040_0000));

      // 32 x 0.25 x 0.5 = 4.0 -> 0.96875
      run_eval("nogap", 32'h0, 32'h0040_0000, 32'h0080_0000, 1'b0, 0,
               1'b0, 32'h00F8_0000, spx(32'h0007_C000));
      run_eval("gap", 32'h0, 32'h0040_0000, 32'h0080_0000, 1'b1, 5,
               1'b1, 32'h00F8_0000, spx(32'h0007_C000));
      step;
      chk("start_in_done_ignored", {31'b0, busy}, 32'd0);

      // single-input instance: 1.0*1.0 -> sigmoid(1.0) = 0.75
      bias   = 32'h0;
      start1 = 1'b1;
      step;
      start1 = 1'b0;
      chk("n1_rdy", {31'b0, in_ready1}, 32'd1);
      prev_activ = 32'h0100_0000;
      weight     = 32'h0100_0000;
      in_valid   = 1'b1;
      step;
      in_valid = 1'b0;
      chk("n1_main_idle", {31'b0, busy}, 32'd0);
      lat = 1;
      while (!out_valid1 && lat < 10) begin
         step;
         lat++;
      end
      chk("n1_lat", lat, EXP_LAT);
      chk("n1_activ", activ1, 32'h00C0_0000);
      chk("n1_sp", sigma_prime1, spx(32'h0030_0000));
      out_ready1 = 1'b1;
      step;
      out_ready1 = 1'b0;
      chk("n1_idle", {31'b0, busy1}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
